// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for the RV32I-subset core: sequences fetch/decode/execute/writeback
// and drives every datapath select and write enable, with optional memory handshake and trap.
module multicycle_ctrl_fsm #(
    parameter int ALU_W         = 3,
    parameter bit MEM_HANDSHAKE = 1'b0,
    parameter bit BRANCH_BNE    = 1'b1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [6:0]       OP,
    input  logic [2:0]       FUNCT3,
    input  logic             FUNCT7B5,
    input  logic             ZERO,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [ALU_W-1:0] ALUControl,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic             Illegal,
    output logic [3:0]       State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_e     state_q, state_d;
    logic       mem_rdy;
    logic       alu_legal, br_legal;
    logic       pc_we, ir_we, mem_we, reg_we, ill;
    logic [2:0] alu_op;

    // Without the handshake the memory is treated as always ready.
    assign mem_rdy   = !MEM_HANDSHAKE || MemReady;
    assign alu_legal = (FUNCT3 == 3'b000) || (FUNCT3 == 3'b010) ||
                       (FUNCT3 == 3'b110) || (FUNCT3 == 3'b111);
    assign br_legal  = (FUNCT3 == 3'b000) || (BRANCH_BNE && (FUNCT3 == 3'b001));

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_ok);
        logic [2:0] r;
        r = ALU_ADD;
        case (f3)
            3'b000:  r = sub_ok ? ALU_SUB : ALU_ADD;
            3'b010:  r = ALU_SLT;
            3'b110:  r = ALU_OR;
            3'b111:  r = ALU_AND;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        ill       = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        alu_op    = ALU_ADD;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ImmSrc    = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_we     = mem_rdy;
                pc_we     = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
                // Illegal funct3 values are caught here so EXEC never sees them.
                case (OP)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = alu_legal ? S_EXECR : S_TRAP;
                    OP_I:         state_d = alu_legal ? S_EXECI : S_TRAP;
                    OP_BR:        state_d = br_legal ? S_BRANCH : S_TRAP;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (OP == OP_SW) ? 2'b01 : 2'b00;
                state_d = (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_we    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_we = 1'b1;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = alu_dec(FUNCT3, FUNCT7B5);
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = alu_dec(FUNCT3, 1'b0);
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                alu_op  = ALU_SUB;
                ImmSrc  = 2'b10;
                pc_we   = ((FUNCT3 == 3'b000) && ZERO) ||
                          (BRANCH_BNE && (FUNCT3 == 3'b001) && !ZERO);
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pc_we   = 1'b1;
                state_d = S_ALUWB;
            end
            S_TRAP: begin
                ill = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are gated by CLR so nothing writes while reset is held, even between edges.
    assign PCWrite    = pc_we & CLR;
    assign IRWrite    = ir_we & CLR;
    assign MemWrite   = mem_we & CLR;
    assign RegWrite   = reg_we & CLR;
    assign Illegal    = ill & CLR;
    assign ALUControl = ALU_W'(alu_op);
    assign State      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: three parameter variants, table-driven cycle vectors
// checked through a scoreboard queue, plus hand sequences for traps and async reset.
module tb_multicycle_ctrl_fsm;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic [6:0] OP = 7'd0;
    logic [2:0] FUNCT3 = 3'd0;
    logic       FUNCT7B5 = 1'b0, ZERO = 1'b0, MemReady = 1'b1;

    logic       PCWrite_w [3], AdrSrc_w [3], MemWrite_w [3], IRWrite_w [3];
    logic       RegWrite_w [3], Illegal_w [3];
    logic [1:0] ResultSrc_w [3], ALUSrcA_w [3], ALUSrcB_w [3], ImmSrc_w [3];
    logic [2:0] ALUControl_w [3];
    logic [3:0] State_w [3];

    always #5 CLK = ~CLK;

    // dut 0: defaults; dut 1: memory handshake; dut 2: BNE disabled
    multicycle_ctrl_fsm #(.ALU_W(3), .MEM_HANDSHAKE(1'b0), .BRANCH_BNE(1'b1)) u_dut0 (
        .CLK(CLK), .CLR(CLR), .OP(OP), .FUNCT3(FUNCT3), .FUNCT7B5(FUNCT7B5), .ZERO(ZERO),
        .MemReady(MemReady), .PCWrite(PCWrite_w[0]), .AdrSrc(AdrSrc_w[0]),
        .MemWrite(MemWrite_w[0]), .IRWrite(IRWrite_w[0]), .ResultSrc(ResultSrc_w[0]),
        .ALUControl(ALUControl_w[0]), .ALUSrcA(ALUSrcA_w[0]), .ALUSrcB(ALUSrcB_w[0]),
        .ImmSrc(ImmSrc_w[0]), .RegWrite(RegWrite_w[0]), .Illegal(Illegal_w[0]),
        .State(State_w[0]));
    multicycle_ctrl_fsm #(.ALU_W(3), .MEM_HANDSHAKE(1'b1), .BRANCH_BNE(1'b1)) u_dut1 (
        .CLK(CLK), .CLR(CLR), .OP(OP), .FUNCT3(FUNCT3), .FUNCT7B5(FUNCT7B5), .ZERO(ZERO),
        .MemReady(MemReady), .PCWrite(PCWrite_w[1]), .AdrSrc(AdrSrc_w[1]),
        .MemWrite(MemWrite_w[1]), .IRWrite(IRWrite_w[1]), .ResultSrc(ResultSrc_w[1]),
        .ALUControl(ALUControl_w[1]), .ALUSrcA(ALUSrcA_w[1]), .ALUSrcB(ALUSrcB_w[1]),
        .ImmSrc(ImmSrc_w[1]), .RegWrite(RegWrite_w[1]), .Illegal(Illegal_w[1]),
        .State(State_w[1]));
    multicycle_ctrl_fsm #(.ALU_W(3), .MEM_HANDSHAKE(1'b0), .BRANCH_BNE(1'b0)) u_dut2 (
        .CLK(CLK), .CLR(CLR), .OP(OP), .FUNCT3(FUNCT3), .FUNCT7B5(FUNCT7B5), .ZERO(ZERO),
        .MemReady(MemReady), .PCWrite(PCWrite_w[2]), .AdrSrc(AdrSrc_w[2]),
        .MemWrite(MemWrite_w[2]), .IRWrite(IRWrite_w[2]), .ResultSrc(ResultSrc_w[2]),
        .ALUControl(ALUControl_w[2]), .ALUSrcA(ALUSrcA_w[2]), .ALUSrcB(ALUSrcB_w[2]),
        .ImmSrc(ImmSrc_w[2]), .RegWrite(RegWrite_w[2]), .Illegal(Illegal_w[2]),
        .State(State_w[2]));

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
    // write-enable vector order: {PCWrite, IRWrite, MemWrite, RegWrite, Illegal}
    localparam logic [4:0] W0 = 5'b00000, WF = 5'b11000, WP = 5'b10000;
    localparam logic [4:0] WM = 5'b00100, WR = 5'b00010, WI = 5'b00001;
    // field mask bits of {ResultSrc, AdrSrc, ALUControl, ALUSrcA, ALUSrcB, ImmSrc}
    localparam logic [11:0] M_RS = 12'hC00, M_AD = 12'h200, M_AL = 12'h1C0;
    localparam logic [11:0] M_SA = 12'h030, M_SB = 12'h00C, M_IM = 12'h003;

    typedef struct {
        int d; bit clr; logic [6:0] op; logic [2:0] f3; bit f7; bit z; bit rdy;
        logic [3:0] st; logic [4:0] we; int alu; int imm;
    } vec_t;
    typedef struct {
        string name; int d; logic [3:0] st; logic [4:0] we; logic [11:0] v; logic [11:0] m;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   checks = 0, failures = 0;

    function automatic vec_t V(int d, bit clr, logic [6:0] op, logic [2:0] f3, bit f7, bit z,
                               bit rdy, logic [3:0] st, logic [4:0] we, int alu = -1,
                               int imm = -1);
        vec_t r;
        r.d = d; r.clr = clr; r.op = op; r.f3 = f3; r.f7 = f7; r.z = z; r.rdy = rdy;
        r.st = st; r.we = we; r.alu = alu; r.imm = imm;
        return r;
    endfunction

    // Mux settings the state table fixes for each state; unlisted fields are unchecked.
    function automatic exp_t mk_exp(string name, int d, logic [3:0] st, logic [4:0] we,
                                    int alu, int imm);
        exp_t e;
        e.name = name; e.d = d; e.st = st; e.we = we;
        case (st)
            4'd0:  begin e.v = {2'b10, 1'b0, 3'b000, 2'b00, 2'b10, 2'b00}; e.m = M_RS|M_AD|M_AL|M_SA|M_SB; end
            4'd1:  begin e.v = {2'b00, 1'b0, 3'b000, 2'b01, 2'b01, 2'b10}; e.m = M_AL|M_SA|M_SB|M_IM; end
            4'd2:  begin e.v = {2'b00, 1'b0, 3'b000, 2'b10, 2'b01, 2'b00}; e.m = M_AL|M_SA|M_SB; end
            4'd3:  begin e.v = {2'b00, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00}; e.m = M_RS|M_AD; end
            4'd4:  begin e.v = {2'b01, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00}; e.m = M_RS; end
            4'd5:  begin e.v = {2'b00, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00}; e.m = M_RS|M_AD; end
            4'd6:  begin e.v = {2'b00, 1'b0, 3'b000, 2'b10, 2'b00, 2'b00}; e.m = M_SA|M_SB; end
            4'd7:  begin e.v = {2'b00, 1'b0, 3'b000, 2'b10, 2'b01, 2'b00}; e.m = M_SA|M_SB|M_IM; end
            4'd8:  begin e.v = {2'b00, 1'b0, 3'b000, 2'b00, 2'b00, 2'b00}; e.m = M_RS; end
            4'd9:  begin e.v = {2'b00, 1'b0, 3'b001, 2'b10, 2'b00, 2'b10}; e.m = M_RS|M_AL|M_SA|M_SB|M_IM; end
            4'd10: begin e.v = {2'b00, 1'b0, 3'b000, 2'b01, 2'b10, 2'b00}; e.m = M_RS|M_AL|M_SA|M_SB; end
            default: begin e.v = 12'h000; e.m = 12'h000; end
        endcase
        if (alu >= 0) begin e.v[8:6] = 3'(alu); e.m = e.m | M_AL; end
        if (imm >= 0) begin e.v[1:0] = 2'(imm); e.m = e.m | M_IM; end
        return e;
    endfunction

    task automatic compare_one();
        exp_t e;
        logic [3:0]  st_a;
        logic [4:0]  we_a;
        logic [11:0] f_a;
        e = sb_q.pop_front();
        st_a = State_w[e.d];
        we_a = {PCWrite_w[e.d], IRWrite_w[e.d], MemWrite_w[e.d], RegWrite_w[e.d], Illegal_w[e.d]};
        f_a  = {ResultSrc_w[e.d], AdrSrc_w[e.d], ALUControl_w[e.d], ALUSrcA_w[e.d],
                ALUSrcB_w[e.d], ImmSrc_w[e.d]};
        checks++;
        if (st_a !== e.st || we_a !== e.we || (f_a & e.m) !== (e.v & e.m)) begin
            failures++;
            $display("FAIL %s dut%0d: got state=%0d we=%b fields=%h, want state=%0d we=%b fields=%h (mask %h)",
                     e.name, e.d, st_a, we_a, f_a & e.m, e.st, e.we, e.v & e.m, e.m);
        end
    endtask

    task automatic step(vec_t t, string name);
        @(posedge CLK);
        #1;
        CLR = t.clr; OP = t.op; FUNCT3 = t.f3; FUNCT7B5 = t.f7; ZERO = t.z; MemReady = t.rdy;
        sb_q.push_back(mk_exp(name, t.d, t.st, t.we, t.alu, t.imm));
        @(negedge CLK);
        compare_one();
    endtask

    initial begin
        // dut0: reset, lw, sw
        tbl.push_back(V(0, 0, LW, 3'b010, 0, 0, 1, 4'd0, W0));
        tbl.push_back(V(0, 1, LW, 3'b010, 0, 0, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, LW, 3'b010, 0, 0, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, LW, 3'b010, 0, 0, 1, 4'd2, W0, -1, 0));
        tbl.push_back(V(0, 1, LW, 3'b010, 0, 0, 1, 4'd3, W0));
        tbl.push_back(V(0, 1, LW, 3'b010, 0, 0, 1, 4'd4, WR));
        tbl.push_back(V(0, 1, SW, 3'b010, 0, 0, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, SW, 3'b010, 0, 0, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, SW, 3'b010, 0, 0, 1, 4'd2, W0, -1, 1));
        tbl.push_back(V(0, 1, SW, 3'b010, 0, 0, 1, 4'd5, WM));
        // R sub, R add, R or, I add with bit30 set, I slt
        tbl.push_back(V(0, 1, RT, 3'b000, 1, 0, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, RT, 3'b000, 1, 0, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, RT, 3'b000, 1, 0, 1, 4'd6, W0, 1));
        tbl.push_back(V(0, 1, RT, 3'b000, 1, 0, 1, 4'd8, WR));
        tbl.push_back(V(0, 1, RT, 3'b000, 0, 0, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, RT, 3'b000, 0, 0, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, RT, 3'b000, 0, 0, 1, 4'd6, W0, 0));
        tbl.push_back(V(0, 1, RT, 3'b000, 0, 0, 1, 4'd8, WR));
        tbl.push_back(V(0, 1, RT, 3'b110, 0, 0, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, RT, 3'b110, 0, 0, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, RT, 3'b110, 0, 0, 1, 4'd6, W0, 3));
        tbl.push_back(V(0, 1, RT, 3'b110, 0, 0, 1, 4'd8, WR));
        tbl.push_back(V(0, 1, IT, 3'b000, 1, 0, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, IT, 3'b000, 1, 0, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, IT, 3'b000, 1, 0, 1, 4'd7, W0, 0));
        tbl.push_back(V(0, 1, IT, 3'b000, 1, 0, 1, 4'd8, WR));
        tbl.push_back(V(0, 1, IT, 3'b010, 0, 0, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, IT, 3'b010, 0, 0, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, IT, 3'b010, 0, 0, 1, 4'd7, W0, 5));
        tbl.push_back(V(0, 1, IT, 3'b010, 0, 0, 1, 4'd8, WR));
        // branches: beq taken / not taken, bne taken / not taken
        tbl.push_back(V(0, 1, BR, 3'b000, 0, 1, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, BR, 3'b000, 0, 1, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, BR, 3'b000, 0, 1, 1, 4'd9, WP));
        tbl.push_back(V(0, 1, BR, 3'b000, 0, 0, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, BR, 3'b000, 0, 0, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, BR, 3'b000, 0, 0, 1, 4'd9, W0));
        tbl.push_back(V(0, 1, BR, 3'b001, 0, 0, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, BR, 3'b001, 0, 0, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, BR, 3'b001, 0, 0, 1, 4'd9, WP));
        tbl.push_back(V(0, 1, BR, 3'b001, 0, 1, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, BR, 3'b001, 0, 1, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, BR, 3'b001, 0, 1, 1, 4'd9, W0));
        // jal
        tbl.push_back(V(0, 1, JL, 3'b000, 0, 0, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, JL, 3'b000, 0, 0, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, JL, 3'b000, 0, 0, 1, 4'd10, WP));
        tbl.push_back(V(0, 1, JL, 3'b000, 0, 0, 1, 4'd8, WR));
        // illegal funct3 on R-type and branch trap at DECODE, recovered by CLR
        tbl.push_back(V(0, 1, RT, 3'b001, 0, 0, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, RT, 3'b001, 0, 0, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, RT, 3'b001, 0, 0, 1, 4'd11, WI));
        tbl.push_back(V(0, 1, RT, 3'b001, 0, 0, 1, 4'd11, WI));
        tbl.push_back(V(0, 0, BR, 3'b010, 0, 0, 1, 4'd0, W0));
        tbl.push_back(V(0, 1, BR, 3'b010, 0, 0, 1, 4'd0, WF));
        tbl.push_back(V(0, 1, BR, 3'b010, 0, 0, 1, 4'd1, W0));
        tbl.push_back(V(0, 1, BR, 3'b010, 0, 0, 1, 4'd11, WI));
        // dut2: BNE disabled traps
        tbl.push_back(V(2, 0, BR, 3'b001, 0, 0, 1, 4'd0, W0));
        tbl.push_back(V(2, 1, BR, 3'b001, 0, 0, 1, 4'd0, WF));
        tbl.push_back(V(2, 1, BR, 3'b001, 0, 0, 1, 4'd1, W0));
        tbl.push_back(V(2, 1, BR, 3'b001, 0, 0, 1, 4'd11, WI));
        // dut1: handshake on sw (3 wait cycles in MEMWRITE) and lw (2 waits in MEMREAD)
        tbl.push_back(V(1, 0, SW, 3'b010, 0, 0, 1, 4'd0, W0));
        tbl.push_back(V(1, 1, SW, 3'b010, 0, 0, 0, 4'd0, W0));
        tbl.push_back(V(1, 1, SW, 3'b010, 0, 0, 1, 4'd0, WF));
        tbl.push_back(V(1, 1, SW, 3'b010, 0, 0, 0, 4'd1, W0));
        tbl.push_back(V(1, 1, SW, 3'b010, 0, 0, 0, 4'd2, W0, -1, 1));
        tbl.push_back(V(1, 1, SW, 3'b010, 0, 0, 0, 4'd5, WM));
        tbl.push_back(V(1, 1, SW, 3'b010, 0, 0, 0, 4'd5, WM));
        tbl.push_back(V(1, 1, SW, 3'b010, 0, 0, 0, 4'd5, WM));
        tbl.push_back(V(1, 1, SW, 3'b010, 0, 0, 1, 4'd5, WM));
        tbl.push_back(V(1, 1, LW, 3'b010, 0, 0, 1, 4'd0, WF));
        tbl.push_back(V(1, 1, LW, 3'b010, 0, 0, 1, 4'd1, W0));
        tbl.push_back(V(1, 1, LW, 3'b010, 0, 0, 0, 4'd2, W0, -1, 0));
        tbl.push_back(V(1, 1, LW, 3'b010, 0, 0, 0, 4'd3, W0));
        tbl.push_back(V(1, 1, LW, 3'b010, 0, 0, 0, 4'd3, W0));
        tbl.push_back(V(1, 1, LW, 3'b010, 0, 0, 1, 4'd3, W0));
        tbl.push_back(V(1, 1, LW, 3'b010, 0, 0, 1, 4'd4, WR));
        tbl.push_back(V(1, 1, LW, 3'b010, 0, 0, 1, 4'd0, WF));

        repeat (2) @(posedge CLK);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // illegal opcode: TRAP holds for 10 cycles with only Illegal set, then CLR clears it
        step(V(0, 0, 7'b1111111, 3'b000, 0, 0, 1, 4'd0, W0), "ill_rst");
        step(V(0, 1, 7'b1111111, 3'b000, 0, 0, 1, 4'd0, WF), "ill_fetch");
        step(V(0, 1, 7'b1111111, 3'b000, 0, 0, 1, 4'd1, W0), "ill_decode");
        for (int k = 0; k < 10; k++)
            step(V(0, 1, 7'b1111111, 3'b000, 0, 0, 1, 4'd11, WI), $sformatf("ill_trap%0d", k));
        step(V(0, 0, 7'b1111111, 3'b000, 0, 0, 1, 4'd0, W0), "ill_clr");
        step(V(0, 1, SW, 3'b000, 0, 0, 1, 4'd0, WF), "ill_recover");

        // async reset mid-store: MemWrite must drop as soon as CLR falls, between edges
        step(V(0, 1, SW, 3'b000, 0, 0, 1, 4'd1, W0), "abort_dec");
        step(V(0, 1, SW, 3'b000, 0, 0, 1, 4'd2, W0, -1, 1), "abort_adr");
        step(V(0, 1, SW, 3'b000, 0, 0, 1, 4'd5, WM), "abort_mw");
        #2;
        CLR = 1'b0;
        #1;
        sb_q.push_back(mk_exp("abort_async", 0, 4'd0, W0, -1, -1));
        compare_one();
        step(V(0, 0, SW, 3'b000, 0, 0, 1, 4'd0, W0), "abort_hold");
        step(V(0, 1, SW, 3'b000, 0, 0, 1, 4'd0, WF), "abort_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
